// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, buffers the
// returned word for the decoder and honours redirects at any point.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] raw_instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] raw_instr_q, raw_instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Unsigned add wraps modulo 2^32, so 32'hFFFF_FFFC steps to 32'h0.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    raw_instr_d = raw_instr_q;
    instr_pc_d  = instr_pc_q;

    if (redirect_i) begin
      pc_d = align_word(redirect_pc_i);
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (imem_ready_i) begin
          state_d   = WAIT;
          // The accepted request targets the old pc; its reply must be dropped.
          discard_d = redirect_i;
        end
      end

      WAIT: begin
        if (redirect_i) begin
          if (imem_rvalid_i) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (discard_q) begin
            state_d   = REQ;
            discard_d = 1'b0;
          end else begin
            state_d     = FULL;
            raw_instr_d = imem_rdata_i;
            instr_pc_d  = pc_q;
            pc_d        = next_word(pc_q);
          end
        end
      end

      FULL: begin
        if (redirect_i || instr_ready_i) begin
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= align_word(RESET_PC);
      discard_q   <= 1'b0;
      raw_instr_q <= 32'h0;
      instr_pc_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      raw_instr_q <= raw_instr_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  // Every output is a register or a decode of state_q only.
  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == FULL);
  assign raw_instr_o   = raw_instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses and instructions are
// queued by the stimulus; independent monitors pop and compare.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] raw_instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .raw_instr_o   (raw_instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_lat = 0;
  int instr_seen = 0;
  int req_seen = 0;
  bit chk_spacing = 0;
  int last_cyc = -1;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic [31:0] pend_addr[$];
  int          pend_cnt[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_instr(input int target, input int budget);
    int k;
    k = 0;
    while (instr_seen < target && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (instr_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_instr: seen %0d need %0d", instr_seen, target);
    end
  endtask

  task automatic wait_req(input int target, input int budget);
    int k;
    k = 0;
    while (req_seen < target && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (req_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_req: seen %0d need %0d", req_seen, target);
    end
  endtask

  // Memory model: replies addr ^ XORK, mem_lat cycles after the accepting edge.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req_o === 1'b1 && imem_ready_i === 1'b1) begin
        pend_addr.push_back(imem_addr_o);
        pend_cnt.push_back(mem_lat);
      end
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      if (pend_cnt.size() > 0) begin
        if (pend_cnt[0] == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = pend_addr[0] ^ XORK;
          void'(pend_addr.pop_front());
          void'(pend_cnt.pop_front());
        end else begin
          pend_cnt[0] = pend_cnt[0] - 1;
        end
      end
    end
  end

  // Request monitor: every accepted request must match the next expected address.
  initial begin : mon_req
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_req_o === 1'b1 && imem_ready_i === 1'b1) begin
        req_seen++;
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h, none expected", imem_addr_o);
        end else begin
          e = exp_req.pop_front();
          chk("req_addr", imem_addr_o, e);
        end
      end
    end
  end

  // Instruction monitor: each new presentation must match the next expected pc.
  initial begin : mon_instr
    logic        vprev;
    logic [31:0] e;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid_o === 1'b1 && !vprev) begin
        instr_seen++;
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc_o);
        end else begin
          e = exp_pc.pop_front();
          chk("instr_pc", instr_pc_o, e);
          chk("instr_data", raw_instr_o, e ^ XORK);
        end
        if (chk_spacing && last_cyc >= 0) chk("spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
      end
      vprev = (instr_valid_o === 1'b1);
    end
  end

  initial begin : stim
    int t;
    rst           = 1'b1;
    imem_ready_i  = 1'b0;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (3) step();

    @(negedge clk);
    chk("rst_req", {31'h0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'h0, instr_valid_o}, 32'd0);
    chk("rst_raw", raw_instr_o, 32'h0);
    chk("rst_ipc", instr_pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, RPC);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'h0, imem_req_o}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'h0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, RPC);

    // Memory not ready: request held with a stable address.
    repeat (4) begin
      @(negedge clk);
      chk("stall_req", {31'h0, imem_req_o}, 32'd1);
      chk("stall_addr", imem_addr_o, RPC);
    end
    chk("stall_no_accept", 32'(req_seen), 32'd0);

    // Zero-wait streaming of four instructions.
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    chk_spacing = 1'b1;
    last_cyc = -1;
    t = instr_seen + 4;
    step();
    imem_ready_i = 1'b1;
    wait_instr(t, 40);
    step();
    imem_ready_i = 1'b0;
    chk_spacing = 1'b0;

    // Redirect while waiting; the late reply is dropped.
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h100);
    exp_pc.push_back(32'h100);
    mem_lat = 2;
    t = req_seen + 1;
    step();
    imem_ready_i = 1'b1;
    wait_req(t, 10);
    t = instr_seen + 1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    mem_lat       = 0;
    step();
    redirect_i = 1'b0;
    wait_instr(t, 40);
    step();
    imem_ready_i = 1'b0;

    // Decoder stall in FULL, then redirect together with ready.
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h200);
    exp_pc.push_back(32'h104);
    exp_pc.push_back(32'h200);
    t = instr_seen + 1;
    step();
    instr_ready_i = 1'b0;
    imem_ready_i  = 1'b1;
    wait_instr(t, 40);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, instr_valid_o}, 32'd1);
      chk("hold_pc", instr_pc_o, 32'h104);
    end
    t = instr_seen + 1;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("redir_full_valid", {31'h0, instr_valid_o}, 32'd0);
    chk("redir_full_addr", imem_addr_o, 32'h200);
    wait_instr(t, 40);
    step();
    imem_ready_i = 1'b0;

    // Redirect to the top word; the following fetch wraps to zero.
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    t = instr_seen + 2;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i   = 1'b0;
    imem_ready_i = 1'b1;
    @(negedge clk);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    wait_instr(t, 60);
    step();
    imem_ready_i = 1'b0;

    // Reset during WAIT with a stale reply arriving after reset.
    exp_req.push_back(32'h4);
    exp_req.push_back(RPC);
    exp_pc.push_back(RPC);
    mem_lat = 1;
    t = req_seen + 1;
    step();
    imem_ready_i = 1'b1;
    wait_req(t, 10);
    step();
    rst          = 1'b1;
    imem_ready_i = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'h0, instr_valid_o}, 32'd0);
    chk("post_rst_req", {31'h0, imem_req_o}, 32'd0);
    chk("post_rst_raw", raw_instr_o, 32'h0);
    chk("post_rst_ipc", instr_pc_o, 32'h0);
    @(negedge clk);
    chk("restart_req", {31'h0, imem_req_o}, 32'd1);
    chk("restart_addr", imem_addr_o, RPC);
    chk("restart_valid", {31'h0, instr_valid_o}, 32'd0);
    mem_lat = 0;
    t = instr_seen + 1;
    step();
    imem_ready_i = 1'b1;
    wait_instr(t, 40);
    step();
    imem_ready_i = 1'b0;

    repeat (3) step();
    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("instr_queue_empty", 32'(exp_pc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
